// File: rtl/sha256_pkg.sv
// sha256_pkg: round constants, initial hash values, FSM state type,
// working-variable bundle and the FIPS 180-4 logical functions.
package sha256_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ROUND,
      UPDATE,
      DONE
   } state_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [31:0] d;
      logic [31:0] e;
      logic [31:0] f;
      logic [31:0] g;
      logic [31:0] h;
   } work_t;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [31:0] IV256 [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] IV224 [8] = '{
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
   };

   function automatic logic [31:0] ch(
      input logic [31:0] x,
      input logic [31:0] y,
      input logic [31:0] z
   );
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(
      input logic [31:0] x,
      input logic [31:0] y,
      input logic [31:0] z
   );
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return {x[1:0], x[31:2]}
           ^ {x[12:0], x[31:13]}
           ^ {x[21:0], x[31:22]};
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return {x[5:0], x[31:6]}
           ^ {x[10:0], x[31:11]}
           ^ {x[24:0], x[31:25]};
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return {x[6:0], x[31:7]}
           ^ {x[17:0], x[31:18]}
           ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return {x[16:0], x[31:17]}
           ^ {x[18:0], x[31:19]}
           ^ {10'b0, x[31:10]};
   endfunction

endpackage

// File: rtl/sha256_stream_core_round.sv
// sha256_round: one combinational SHA-256 compression round.
// Ports: cur (a..h in), k (K_t), w (W_t), nxt (a..h out).
module sha256_round
   import sha256_pkg::*;
(
   input  work_t       cur,
   input  logic [31:0] k,
   input  logic [31:0] w,
   output work_t       nxt
);

   logic [31:0] t1;
   logic [31:0] t2;

   assign t1 = cur.h + bsig1(cur.e)
             + ch(cur.e, cur.f, cur.g) + k + w;
   assign t2 = bsig0(cur.a) + maj(cur.a, cur.b, cur.c);

   always_comb begin
      nxt   = cur;
      nxt.a = t1 + t2;
      nxt.b = cur.a;
      nxt.c = cur.b;
      nxt.d = cur.c;
      nxt.e = cur.d + t1;
      nxt.f = cur.e;
      nxt.g = cur.f;
      nxt.h = cur.g;
   end

endmodule

// File: rtl/sha256_stream_core.sv
// sha256_stream_core: streaming SHA-256/224 with internal padding.
// Ports: clk, reset, start/mode_224/msg_len, in_* stream, busy, out_* digest.
module sha256_stream_core
   import sha256_pkg::*;
#(
   parameter int LEN_W       = 32,
   parameter bit SUPPORT_224 = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             mode_224,
   input  logic [LEN_W-1:0] msg_len,
   input  logic             in_valid,
   input  logic [31:0]      in_data,
   output logic             in_ready,
   output logic             busy,
   output logic             out_valid,
   output logic [255:0]     digest,
   input  logic             out_ready
);

   if (LEN_W < 3 || LEN_W + 3 > 64) begin : g_len_chk
      $error("LEN_W must be in 3..61");
   end

   state_t           state_q;
   state_t           state_d;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] byte_cnt;
   logic [LEN_W-1:0] bytes_left;
   logic             mode_q;
   logic [3:0]       wcnt;
   logic [5:0]       tcnt;
   logic             pad_q;
   logic             fin_q;
   logic [31:0]      h_q [8];
   logic [31:0]      w_q [16];
   work_t            wk_q;
   work_t            wk_nxt;
   logic [31:0]      w_new;
   logic [31:0]      load_word;
   logic [63:0]      bitlen;
   logic             data_need;
   logic             full_word;
   logic             word_adv;
   logic             len_word;

   assign bytes_left = len_q - byte_cnt;
   assign data_need  = |bytes_left;
   assign full_word  = |bytes_left[LEN_W-1:2];
   assign word_adv   = data_need ? in_valid : 1'b1;
   assign bitlen     = 64'({len_q, 3'b000});
   // Length goes in words 14/15 once data and the 0x80 byte are placed.
   assign len_word   = !data_need && pad_q && wcnt == 4'd14;

   assign w_new = ssig1(w_q[14]) + w_q[9]
                + ssig0(w_q[1]) + w_q[0];

   sha256_round u_round (
      .cur (wk_q),
      .k   (K[tcnt]),
      .w   (w_q[0]),
      .nxt (wk_nxt)
   );

   always_comb begin
      load_word = 32'h0;
      if (data_need) begin
         if (full_word) begin
            load_word = in_data;
         end else begin
            unique case (bytes_left[1:0])
               2'd1:    load_word = {in_data[31:24], 24'h800000};
               2'd2:    load_word = {in_data[31:16], 16'h8000};
               default: load_word = {in_data[31:8], 8'h80};
            endcase
         end
      end else if (!pad_q) begin
         load_word = 32'h8000_0000;
      end else if (len_word) begin
         load_word = bitlen[63:32];
      end else if (fin_q && wcnt == 4'd15) begin
         load_word = bitlen[31:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      busy      = 1'b1;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) state_d = LOAD;
         end
         LOAD: begin
            in_ready = data_need;
            if (word_adv && wcnt == 4'd15) state_d = ROUND;
         end
         ROUND: begin
            if (tcnt == 6'd63) state_d = UPDATE;
         end
         UPDATE: begin
            state_d = fin_q ? DONE : LOAD;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         len_q    <= '0;
         byte_cnt <= '0;
         mode_q   <= 1'b0;
         wcnt     <= '0;
         tcnt     <= '0;
         pad_q    <= 1'b0;
         fin_q    <= 1'b0;
         wk_q     <= '0;
         for (int i = 0; i < 8; i++)  h_q[i] <= '0;
         for (int i = 0; i < 16; i++) w_q[i] <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  len_q    <= msg_len;
                  mode_q   <= SUPPORT_224 ? mode_224 : 1'b0;
                  byte_cnt <= '0;
                  wcnt     <= '0;
                  tcnt     <= '0;
                  pad_q    <= 1'b0;
                  fin_q    <= 1'b0;
                  for (int i = 0; i < 8; i++) begin
                     h_q[i] <= (SUPPORT_224 && mode_224)
                             ? IV224[i] : IV256[i];
                  end
               end
            end
            LOAD: begin
               if (word_adv) begin
                  for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
                  w_q[15] <= load_word;
                  wcnt    <= wcnt + 4'd1;
                  if (data_need) begin
                     byte_cnt <= byte_cnt
                               + (full_word ? LEN_W'(4) : bytes_left);
                  end
                  if (!data_need || !full_word) pad_q <= 1'b1;
                  if (len_word) fin_q <= 1'b1;
                  if (wcnt == 4'd15) begin
                     wk_q <= {h_q[0], h_q[1], h_q[2], h_q[3],
                              h_q[4], h_q[5], h_q[6], h_q[7]};
                     tcnt <= '0;
                  end
               end
            end
            ROUND: begin
               wk_q <= wk_nxt;
               for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
               w_q[15] <= w_new;
               tcnt    <= tcnt + 6'd1;
            end
            UPDATE: begin
               h_q[0] <= h_q[0] + wk_q.a;
               h_q[1] <= h_q[1] + wk_q.b;
               h_q[2] <= h_q[2] + wk_q.c;
               h_q[3] <= h_q[3] + wk_q.d;
               h_q[4] <= h_q[4] + wk_q.e;
               h_q[5] <= h_q[5] + wk_q.f;
               h_q[6] <= h_q[6] + wk_q.g;
               h_q[7] <= h_q[7] + wk_q.h;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      digest = '0;
      if (out_valid) begin
         digest = {h_q[0], h_q[1], h_q[2], h_q[3],
                   h_q[4], h_q[5], h_q[6], h_q[7]};
         if (mode_q) digest[31:0] = 32'h0;
      end
   end

endmodule

// File: tb/tb_sha256_stream_core.sv
// tb_sha256_stream_core: known-answer and random-message checks
// of sha256_stream_core against a byte-level SHA-256/224 model.
module tb_sha256_stream_core;

   typedef logic [7:0] bq_t [$];

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         mode_224;
   logic [31:0]  msg_len;
   logic         in_valid;
   logic [31:0]  in_data;
   logic         in_ready;
   logic         busy;
   logic         out_valid;
   logic [255:0] digest;
   logic         out_ready;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   sha256_stream_core #(.LEN_W(32), .SUPPORT_224(1'b1)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .mode_224  (mode_224),
      .msg_len   (msg_len),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .busy      (busy),
      .out_valid (out_valid),
      .digest    (digest),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] TK [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   logic [31:0] TIV256 [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };
   logic [31:0] TIV224 [8] = '{
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
   };

   task automatic check(input string tag,
                        input logic [255:0] got,
                        input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] ref_sha(input bq_t m, input bit m224);
      bq_t         p;
      logic [63:0] bits;
      logic [31:0] h [8];
      logic [31:0] v [8];
      logic [31:0] w [64];
      logic [31:0] t1, t2, s0, s1;
      logic [255:0] r;
      p    = m;
      bits = 64'(m.size()) * 64'd8;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
      for (int i = 0; i < 8; i++) h[i] = m224 ? TIV224[i] : TIV256[i];
      for (int b = 0; b < p.size() / 64; b++) begin
         for (int i = 0; i < 16; i++)
            w[i] = {p[64*b+4*i], p[64*b+4*i+1],
                    p[64*b+4*i+2], p[64*b+4*i+3]};
         for (int i = 16; i < 64; i++) begin
            s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
         end
         v = h;
         for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TK[i] + w[i];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
         end
         for (int j = 0; j < 8; j++) h[j] = h[j] + v[j];
      end
      r = {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
      if (m224) r[31:0] = 32'h0;
      return r;
   endfunction

   function automatic bq_t s2q(input string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   // gap: 0 = in_valid always high, >0 = that many idle ready
   // cycles first, <0 = random idle cycles.
   task automatic run_msg(input string tag, input bq_t m,
                          input bit m224, input int gap,
                          input int hold, input bit use_kat,
                          input logic [255:0] kat);
      int n, k, s, lat, rdy_cnt, budget, g;
      logic rdy;
      logic [255:0] exp, dg;
      n   = m.size();
      g   = gap;
      exp = use_kat ? kat : ref_sha(m, m224);
      @(negedge clk);
      start    = 1'b1;
      mode_224 = m224;
      msg_len  = 32'(n);
      s        = cyc;
      @(negedge clk);
      start    = 1'b0;
      mode_224 = 1'($urandom_range(0, 1));
      msg_len  = $urandom;
      k = 0; rdy_cnt = 0; budget = 0;
      while (!out_valid && budget < 2000) begin
         rdy = in_ready;
         if (rdy) begin
            rdy_cnt++;
            if (g > 0) begin
               g--;
               in_valid = 1'b0;
            end else if (g < 0 && $urandom_range(0, 2) == 0) begin
               in_valid = 1'b0;
            end else begin
               in_valid = 1'b1;
               for (int j = 0; j < 4; j++)
                  in_data[31-8*j -: 8] = (4*k+j < n) ? m[4*k+j]
                                       : 8'($urandom_range(0, 255));
            end
         end else begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
         end
         @(negedge clk);
         budget++;
         if (rdy && in_valid) k++;
      end
      in_valid = 1'b0;
      lat = cyc - s;
      check({tag, "/out_valid"}, 256'(out_valid), 256'(1));
      check({tag, "/words"}, 256'(k), 256'((n + 3) / 4));
      if (n == 0) check({tag, "/rdy_cycles"}, 256'(rdy_cnt), 256'(0));
      if (gap == 0)
         check({tag, "/latency"}, 256'(lat),
               256'(1 + ((n + 8) / 64 + 1) * 81));
      dg = digest;
      check({tag, "/digest"}, dg, exp);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "/hold_valid"}, 256'(out_valid), 256'(1));
         check({tag, "/hold_digest"}, digest, dg);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "/busy_after"}, 256'(busy), 256'(0));
      check({tag, "/valid_after"}, 256'(out_valid), 256'(0));
   endtask

   int lens [14] = '{1, 4, 5, 52, 53, 54, 55, 56, 57, 63, 64, 65, 119, 120};

   initial begin
      int vcnt;
      reset = 1'b1; start = 1'b0; mode_224 = 1'b0; msg_len = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst/in_ready", 256'(in_ready), 256'(0));
      check("rst/busy", 256'(busy), 256'(0));
      check("rst/out_valid", 256'(out_valid), 256'(0));
      check("rst/digest", digest, 256'(0));
      // start while reset is asserted must be ignored
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      reset = 1'b0;
      check("rst/start_ignored", 256'(busy), 256'(0));

      run_msg("abc", s2q("abc"), 1'b0, 0, 0, 1'b1,
         256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
      run_msg("empty", s2q(""), 1'b0, 0, 0, 1'b1,
         256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);
      run_msg("abc448",
         s2q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"),
         1'b0, 0, 1, 1'b1,
         256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);
      run_msg("abc224", s2q("abc"), 1'b1, 0, 0, 1'b1,
         {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7,
          32'h0});
      run_msg("backpr", s2q("abc"), 1'b0, 5, 10, 1'b1,
         256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

      // abort at round t=30 of the first block
      @(negedge clk);
      start = 1'b1; mode_224 = 1'b0; msg_len = 32'd3;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_data = 32'h61626300;
      repeat (46) @(negedge clk);
      in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort/busy", 256'(busy), 256'(0));
      check("abort/digest", digest, 256'(0));
      vcnt = 0;
      repeat (120) begin
         @(negedge clk);
         if (out_valid) vcnt++;
      end
      check("abort/no_valid", 256'(vcnt), 256'(0));
      run_msg("abort/abc", s2q("abc"), 1'b0, 0, 0, 1'b1,
         256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

      for (int r = 0; r < 26; r++) begin
         bq_t m;
         int  n;
         n = (r < 14) ? lens[r] : int'($urandom_range(0, 150));
         m = {};
         for (int i = 0; i < n; i++) m.push_back(8'($urandom_range(0, 255)));
         run_msg($sformatf("rnd%0d_len%0d", r, n), m,
                 1'($urandom_range(0, 1)), (r % 3 == 0) ? 0 : -1,
                 int'($urandom_range(0, 4)), 1'b0, 256'(0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sha256_stream_core.md
Name: sha256_stream_core

Overview:
- Streaming SHA-256/SHA-224 hash engine. Successor to the fixed-size `top #(MSG_SIZE,512)` hasher.
- Accepts a message of any byte length up to 2^LEN_W-1 as 32-bit big-endian words over a valid/ready handshake.
- Performs FIPS 180-4 padding internally, iterates over as many 512-bit blocks as needed, and presents the digest on a valid/ready output.
- Sits between the message buffer and the result register/host interface.

Parameters:
- LEN_W, 32: width of the message byte-length input.
- SUPPORT_224, 1: 1 enables SHA-224 mode; 0 forces mode_224 to be ignored (SHA-256 only).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- mode_224  in  1  sampled with start; 1 selects SHA-224.
- msg_len  in  LEN_W  message length in bytes; sampled with start.
- in_valid  in  1  in_data holds a valid message word.
- in_data  in  32  message word, first byte in [31:24].
- in_ready  out  1  core accepts in_data this cycle.
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  digest is valid.
- digest  out  256  H0..H7 concatenated, H0 in [255:224]. SHA-224 gives {H0..H6, 32'h0}.
- out_ready  in  1  consumer accepts the digest.

Behaviour:
- Reset: state goes to IDLE. in_ready, busy and out_valid = 0; digest = 0; all counters = 0. Reset wins over every other input in the same cycle.
- FSM states: IDLE, LOAD, ROUND, UPDATE, DONE.
- IDLE:
  - start=1 latches msg_len and mode (mode forced to 0 if SUPPORT_224=0).
  - Loads H with the SHA-256 or SHA-224 IV.
  - Clears the byte and word counters, then goes to LOAD.
- LOAD fills W[0..15], one word per cycle:
  - Data word: needed while bytes_left > 0. in_ready=1; a word is consumed only on in_valid&in_ready.
  - Last data word: if bytes_left < 4, only the upper bytes_left bytes are kept. The byte after them is 0x80 and the rest are 0.
  - Pad word: needed once bytes_left = 0. in_ready=0; inserted without handshake, one per cycle, in this order:
    - the 0x80000000 word, unless the 0x80 byte was already merged into the last data word;
    - zero words;
    - in the final block, words 14/15 = 64-bit bit length (msg_len × 8, zero-extended).
  - After word 15, go to ROUND.
- Block count = floor((msg_len+8)/64)+1. An extra block is used when fewer than 9 bytes of room remain after the data.
- ROUND:
  - 64 cycles, one compression round per cycle, round counter t = 0..63.
  - Message schedule is a rolling 16-word window (W_t for t ≥ 16 computed in place).
  - Working variables a..h are initialised from H on LOAD→ROUND.
- UPDATE: 1 cycle, H_i += working variable (mod 2^32). Then go to LOAD if blocks remain, else DONE.
- DONE:
  - out_valid=1 and digest is driven from H.
  - Digest stays stable while out_ready=0.
  - On out_valid&out_ready, go to IDLE next cycle.
  - start is ignored in every state except IDLE.
- Latency per block = 16 LOAD cycles (with in_valid held high) + 64 + 1. Example: "abc" gives out_valid 82 cycles after start.
- msg_len = 0: no in_ready pulse; one block of pure padding.
- All arithmetic is mod 2^32. Length fields wider than 64 bits are not supported (LEN_W+3 ≤ 64 is checked at elaboration).
- Reset mid-operation: abort immediately to IDLE. The partial hash is discarded and out_valid is never asserted for the aborted message.

Decomposition:
- Package sha256_pkg:
  - K[0:63] round constants;
  - IV256[0:7] and IV224[0:7];
  - state enum;
  - functions ch, maj, bsig0, bsig1, ssig0, ssig1.
- One sub-module: sha256_round. Combinational; takes a..h, K_t, W_t and returns next a..h. Instantiated once in sha256_stream_core.

Test Plan:
- Message "abc": msg_len=3, in_data=32'h61626300, SHA-256 → digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad; out_valid at cycle 82.
- Empty message: msg_len=0, no input words → e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855; in_ready never high.
- 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (two blocks, pad-boundary case) → 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- SHA-224 "abc" (mode_224=1) → digest[255:32] = 23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, digest[31:0] = 0.
- Backpressure: "abc" with in_valid low for 5 cycles before the word, and out_ready low for 10 cycles after out_valid → same digest; digest stable and out_valid high throughout; busy drops the cycle after out_ready.
- Reset mid-ROUND (t=30), then a new start with "abc": out_valid stays 0 after reset; the second message yields the correct "abc" digest.
